fp8_serial_tx: RTL and testbench

Downstream stage of the 12-bit linear to 8-bit floating-point converter. The block accepts converted samples (sign, 3-bit exponent, 4-bit significand) through a valid/ready handshake and buffers them in a small FIFO. It shifts each sample out MSB-first on a framed single-wire serial link at a parameterised bit rate. Samples offered while the FIFO is full are dropped and counted.

---
 rtl/fp8_serial_tx.sv | 134 +++++++++++++
 tb/tb_fp8_serial_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_serial_tx.sv
// Buffers packed FP8 samples {sign, exp[2:0], sig[3:0]} in a small FIFO and shifts
// each one out MSB-first on a framed single-wire link, CLKS_PER_BIT cycles per bit.
module fp8_serial_tx #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sign,
  input  logic [2:0]               in_exp,
  input  logic [3:0]               in_sig,
  output logic                     in_ready,
  output logic                     ser_out,
  output logic                     ser_frame,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_cnt,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Upstream handshake: a transfer happens on an edge where in_valid && in_ready.
  // in_ready depends only on the registered count, so a pop on the same edge
  // never makes room for a push that was refused at cycle start.

  state_t         state, state_n;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [7:0]     shreg;
  logic [CW-1:0]  clk_cnt;
  logic [2:0]     bit_idx;
  logic           push, drop, pop, cnt_wrap;

  assign in_ready = (fifo_count < FULL) && !rst;
  assign push     = in_valid && in_ready;
  assign drop     = in_valid && !in_ready;
  assign cnt_wrap = (clk_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_sign, in_exp, in_sig};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_wrap && bit_idx == 3'd7) state_n = GAP;
      end
      GAP: begin
        if (cnt_wrap) begin
          if (fifo_count != '0) begin
            pop     = 1'b1;
            state_n = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // clk_cnt paces both SHIFT bits and the GAP; it restarts at every wrap and load.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else if (pop) begin
      shreg   <= mem[rd_ptr];
      clk_cnt <= '0;
      bit_idx <= '0;
    end else if (state != IDLE) begin
      if (cnt_wrap) begin
        clk_cnt <= '0;
        if (state == SHIFT) begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    ser_frame = (state == SHIFT);
    ser_out   = (state == SHIFT) && shreg[7];
    busy      = (state != IDLE) || (fifo_count != '0);
    dbg_state = state;
  end

endmodule

// File: tb/tb_fp8_serial_tx.sv
// Directed bench for fp8_serial_tx: reset, single frame, back-to-back frames,
// overflow, drop saturation, mid-frame reset and simultaneous push/pop.
module tb_fp8_serial_tx;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int TMO   = 200;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic       clk, rst, in_valid, in_sign;
  logic [2:0] in_exp;
  logic [3:0] in_sig;
  logic       in_ready, ser_out, ser_frame, busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [7:0] drop_cnt;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  fp8_serial_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sign(in_sign),
    .in_exp(in_exp), .in_sig(in_sig), .in_ready(in_ready), .ser_out(ser_out),
    .ser_frame(ser_frame), .busy(busy), .fifo_count(fifo_count),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] b);
    in_valid = v;
    {in_sign, in_exp, in_sig} = b;
  endtask

  // Offer one byte, let one edge pass, then check the state seen after that edge.
  task automatic step_push(input string tag, input logic [7:0] b, input int exp_cnt,
                           input logic exp_ready, input int exp_drop,
                           input logic exp_frame, input logic exp_bit);
    drive(1'b1, b);
    tick();
    chk({tag, "_cnt"},   fifo_count, exp_cnt);
    chk({tag, "_ready"}, in_ready,   exp_ready);
    chk({tag, "_drop"},  drop_cnt,   exp_drop);
    chk({tag, "_frame"}, ser_frame,  exp_frame);
    if (exp_frame) chk({tag, "_bit"}, ser_out, exp_bit);
  endtask

  // Check frame samples first..last-1 of byte b; sample 0 is found by waiting.
  task automatic rx_frame(input string tag, input logic [7:0] b, input int first,
                          input int last, output int waited);
    int s0;
    waited = 0;
    if (first == 0) begin
      do begin
        tick();
        waited++;
      end while (ser_frame !== 1'b1 && waited < TMO);
      chk({tag, "_start"}, ser_frame, 1'b1);
      chk({tag, "_bit"},   ser_out,   b[7]);
      s0 = 1;
    end else begin
      s0 = first;
    end
    for (int s = s0; s < last; s++) begin
      tick();
      chk({tag, "_frame"}, ser_frame, 1'b1);
      chk({tag, "_bit"},   ser_out,   b[7 - s / CPB]);
    end
    if (last == 32) begin
      tick();
      chk({tag, "_end"}, ser_frame, 1'b0);
    end
  endtask

  task automatic wait_idle(input string tag, input int bound, output int n);
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_busy"},  busy,      1'b0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    int  w, n, highs;
    logic sat_seen;

    rst = 1'b1;
    drive(1'b0, 8'h00);
    tick();
    tick();
    chk("rst_ready", in_ready,   1'b0);
    chk("rst_out",   ser_out,    1'b0);
    chk("rst_frame", ser_frame,  1'b0);
    chk("rst_busy",  busy,       1'b0);
    chk("rst_cnt",   fifo_count, 0);
    chk("rst_drop",  drop_cnt,   0);
    chk("rst_state", dbg_state,  ST_IDLE);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", in_ready, 1'b1);

    // Single sample 0x5B
    step_push("single_p0", 8'h5B, 1, 1'b1, 0, 1'b0, 1'b0);
    drive(1'b0, 8'h00);
    rx_frame("single", 8'h5B, 0, 32, w);
    chk("single_latency", w, 1);
    chk("single_gap_busy",  busy,      1'b1);
    chk("single_gap_state", dbg_state, ST_GAP);
    wait_idle("single_idle", TMO, n);
    chk("single_gap_len", n, CPB);

    // Back-to-back four bytes
    step_push("b2b_p0", 8'hFF, 1, 1'b1, 0, 1'b0, 1'b0);
    step_push("b2b_p1", 8'h80, 1, 1'b1, 0, 1'b1, 1'b1);
    step_push("b2b_p2", 8'h01, 2, 1'b1, 0, 1'b1, 1'b1);
    step_push("b2b_p3", 8'h00, 3, 1'b1, 0, 1'b1, 1'b1);
    drive(1'b0, 8'h00);
    rx_frame("b2b_f0", 8'hFF, 3, 32, w);
    rx_frame("b2b_f1", 8'h80, 0, 32, w);
    chk("b2b_gap1", w, CPB);
    rx_frame("b2b_f2", 8'h01, 0, 32, w);
    chk("b2b_gap2", w, CPB);
    rx_frame("b2b_f3", 8'h00, 0, 32, w);
    chk("b2b_gap3", w, CPB);
    chk("b2b_drop", drop_cnt, 0);
    wait_idle("b2b_idle", TMO, n);

    // Overflow: seven consecutive offers
    step_push("ovf_p0", 8'h11, 1, 1'b1, 0, 1'b0, 1'b0);
    step_push("ovf_p1", 8'h22, 1, 1'b1, 0, 1'b1, 1'b0);
    step_push("ovf_p2", 8'h33, 2, 1'b1, 0, 1'b1, 1'b0);
    step_push("ovf_p3", 8'h44, 3, 1'b1, 0, 1'b1, 1'b0);
    step_push("ovf_p4", 8'h55, 4, 1'b0, 0, 1'b1, 1'b0);
    step_push("ovf_p5", 8'h66, 4, 1'b0, 1, 1'b1, 1'b0);
    step_push("ovf_p6", 8'h77, 4, 1'b0, 2, 1'b1, 1'b0);
    drive(1'b0, 8'h00);
    rx_frame("ovf_f0", 8'h11, 6, 32, w);
    rx_frame("ovf_f1", 8'h22, 0, 32, w);
    chk("ovf_gap1", w, CPB);
    rx_frame("ovf_f2", 8'h33, 0, 32, w);
    rx_frame("ovf_f3", 8'h44, 0, 32, w);
    rx_frame("ovf_f4", 8'h55, 0, 32, w);
    chk("ovf_gap4", w, CPB);
    wait_idle("ovf_idle", TMO, n);
    chk("ovf_drop_final", drop_cnt, 2);
    chk("ovf_cnt_final",  fifo_count, 0);

    // Drop counter saturation
    sat_seen = 1'b0;
    drive(1'b1, 8'h99);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (drop_cnt === 8'hFF) sat_seen = 1'b1;
      if (sat_seen) chk("sat_hold", drop_cnt, 8'hFF);
    end
    chk("sat_reached", sat_seen, 1'b1);
    drive(1'b0, 8'h00);
    wait_idle("sat_idle", 1000, n);
    chk("sat_after_drain", drop_cnt, 8'hFF);

    // Reset during bit 3 of 0xA5 with two bytes queued
    step_push("mrst_p0", 8'hA5, 1, 1'b1, 255, 1'b0, 1'b0);
    step_push("mrst_p1", 8'h3C, 1, 1'b1, 255, 1'b1, 1'b1);
    step_push("mrst_p2", 8'hC3, 2, 1'b1, 255, 1'b1, 1'b1);
    drive(1'b0, 8'h00);
    rx_frame("mrst_f0", 8'hA5, 2, 14, w);
    chk("mrst_queued", fifo_count, 2);
    rst = 1'b1;
    tick();
    chk("mrst_out",   ser_out,    1'b0);
    chk("mrst_frame", ser_frame,  1'b0);
    chk("mrst_cnt",   fifo_count, 0);
    chk("mrst_drop",  drop_cnt,   0);
    chk("mrst_ready", in_ready,   1'b0);
    chk("mrst_busy",  busy,       1'b0);
    rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ser_frame !== 1'b0) highs++;
    end
    chk("mrst_no_frames", highs, 0);

    // Push on the GAP-exit pop edge with two bytes stored
    step_push("pp_p0", 8'h3E, 1, 1'b1, 0, 1'b0, 1'b0);
    step_push("pp_p1", 8'hC1, 1, 1'b1, 0, 1'b1, 1'b0);
    step_push("pp_p2", 8'h7F, 2, 1'b1, 0, 1'b1, 1'b0);
    drive(1'b0, 8'h00);
    rx_frame("pp_f0", 8'h3E, 2, 32, w);
    for (int i = 0; i < CPB - 1; i++) tick();
    chk("pp_pre_cnt",   fifo_count, 2);
    chk("pp_pre_state", dbg_state,  ST_GAP);
    drive(1'b1, 8'h24);
    tick();
    drive(1'b0, 8'h00);
    chk("pp_cnt",   fifo_count, 2);
    chk("pp_frame", ser_frame,  1'b1);
    chk("pp_bit",   ser_out,    1'b1);
    rx_frame("pp_f1", 8'hC1, 1, 32, w);
    rx_frame("pp_f2", 8'h7F, 0, 32, w);
    chk("pp_gap2", w, CPB);
    rx_frame("pp_f3", 8'h24, 0, 32, w);
    chk("pp_gap3", w, CPB);
    wait_idle("pp_idle", TMO, n);
    chk("pp_drop", drop_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
